int_priority_encoder: RTL

- Interrupt front end for the Mano-style CPU: collects 8 request lines, latches them as pending, masks them, and encodes the highest-priority one to a 3-bit vector.
- Presents the vector with an irq/ack handshake to the control unit's interrupt-cycle logic.
- Inverse of the 3-to-8 one-hot decoder: one-hot/multi-hot request in, binary index out, registered and sequenced.

---
 rtl/int_pkg.sv | 16 +
 rtl/prio_enc8.sv | 21 ++
 rtl/int_priority_encoder.sv | 88 ++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared constants and types for the 8-source interrupt priority encoder.
// Also holds the priority-ordering constant used by the CPU interrupt-cycle decoder.
package int_pkg;

  localparam int N_SRC = 8;
  localparam int VEC_W = $clog2(N_SRC);

  // Source 0 is the most urgent; the lowest set index wins arbitration.
  localparam bit PRIO0_IS_LSB = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit encoder: 8 request bits in, 3-bit index plus valid out.
module prio_enc8
  import int_pkg::*;
(
  input  logic [N_SRC-1:0] req_bits,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last assignment to stick.
  always_comb begin
    idx   = '0;
    valid = |req_bits;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_bits[i]) begin
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_priority_encoder.sv
// Interrupt front end: latches requests as pending, masks them and presents the
// highest-priority source as a registered vector with an irq/ack handshake.
module int_priority_encoder
  import int_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ien,
  input  logic             ack,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  irq_state_e       state_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] mask_reg;
  logic             irq_reg;
  logic [VEC_W-1:0] vec_reg;

  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] elig;
  logic [VEC_W-1:0] enc_idx;
  logic             enc_valid;

  // Clear only the presented source, and only in the cycle the CPU acks it.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
      assign clr[gi] = (state_reg == PRESENT) && ack && (vec_reg == VEC_W'(gi));
    end
  endgenerate

  // OR-ing req in after the clear lets a same-cycle set win over the ack clear.
  assign pending_next = (pending_reg & ~clr) | req;
  assign elig         = pending_reg & mask_reg & {N_SRC{ien}};

  prio_enc8 u_prio_enc8 (
    .req_bits (elig),
    .idx      (enc_idx),
    .valid    (enc_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
      vec_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
      case (state_reg)
        IDLE: begin
          if (enc_valid) begin
            vec_reg   <= enc_idx;
            irq_reg   <= 1'b1;
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          // vec is frozen here regardless of new requests, mask or ien.
          if (ack) begin
            irq_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          irq_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign irq     = irq_reg;
  assign vec     = vec_reg;
  assign pending = pending_reg;
  assign mask    = mask_reg;

endmodule
